// File: rtl/ahb_mem_slave_p.sv
// AHB-Lite memory slave: pipelined address/data phases, programmable wait states, byte lanes, two-cycle ERROR.
// Define AHB_MEM_SLAVE_PROT_EN to reject user-mode writes to the upper half of the memory.
module ahb_mem_slave_p #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic [1:0]            htrans,
    input  logic                  hready,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                state_reg;
    logic [2:0]            wait_cnt_reg;
    logic                  hreadyout_reg;
    logic                  hresp_reg;
    logic [DATA_WIDTH-1:0] hrdata_reg;
    logic                  dphase_reg;
    logic                  dwrite_reg;
    logic [IDX_W-1:0]      didx_reg;
    logic [BYTES-1:0]      dmask_reg;

    logic                  accept;
    logic                  illegal;
    logic                  legal_accept;
    logic                  wr_commit;
    logic                  rd_load;
    logic                  range_err;
    logic                  size_err;
    logic                  align_err;
    logic                  prot_err;
    logic [OFF_W-1:0]      byte_off;
    logic [OFF_W-1:0]      align_mask;
    logic [7:0]            size_bytes;
    logic [IDX_W-1:0]      addr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [BYTES-1:0]      lane_mask;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_inputs;

    assign unused_inputs = ^{hburst, hprot};

    assign byte_off   = haddr[OFF_W-1:0];
    assign addr_idx   = haddr[OFF_W +: IDX_W];
    assign size_bytes = 8'd1 << hsize;
    // Low bits of the transfer size minus one give the alignment mask for any legal size.
    assign align_mask = size_bytes[OFF_W-1:0] - OFF_W'(1);

    assign range_err = (haddr >> (OFF_W + IDX_W)) != '0;
    assign size_err  = hsize > 3'(OFF_W);
    assign align_err = (byte_off & align_mask) != '0;

`ifdef AHB_MEM_SLAVE_PROT_EN
    assign prot_err = hwrite && !hprot[1] && addr_idx[IDX_W-1];
`else
    assign prot_err = 1'b0;
`endif

    assign accept       = hsel && hready && htrans[1] && hreadyout_reg;
    assign illegal      = range_err || size_err || align_err || prot_err;
    assign legal_accept = accept && !illegal;
    assign wr_commit    = dphase_reg && dwrite_reg && hreadyout_reg;

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        assign lane_mask[gi] = (OFF_W'(gi) >= byte_off) &&
                               (9'(gi) < ({{(9-OFF_W){1'b0}}, byte_off} + {1'b0, size_bytes}));
    end

    // Zero-wait reads sample memory at the accept edge; waited reads sample at the last wait edge.
    always_comb begin
        rd_idx  = didx_reg;
        rd_load = 1'b0;
        if (WAIT_STATES == 0) begin
            rd_idx  = addr_idx;
            rd_load = legal_accept && !hwrite;
        end else begin
            rd_load = (state_reg == S_WAIT) && (wait_cnt_reg == 3'd0) && dphase_reg && !dwrite_reg;
        end
        rd_word = mem[rd_idx];
        for (int b = 0; b < BYTES; b++) begin
            if (wr_commit && dmask_reg[b] && (didx_reg == rd_idx))
                rd_word[b*8 +: 8] = hwdata[b*8 +: 8];
        end
    end

    always_ff @(posedge hclk) begin
        if (wr_commit) begin
            for (int b = 0; b < BYTES; b++) begin
                if (dmask_reg[b])
                    mem[didx_reg][b*8 +: 8] <= hwdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_reg     <= S_IDLE;
            wait_cnt_reg  <= '0;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= 1'b0;
            hrdata_reg    <= '0;
            dphase_reg    <= 1'b0;
            dwrite_reg    <= 1'b0;
            didx_reg      <= '0;
            dmask_reg     <= '0;
        end else begin
            if (rd_load)
                hrdata_reg <= rd_word;

            if (accept) begin
                dphase_reg <= !illegal;
                dwrite_reg <= hwrite;
                didx_reg   <= addr_idx;
                dmask_reg  <= lane_mask;
            end else if (hreadyout_reg) begin
                dphase_reg <= 1'b0;
            end

            case (state_reg)
                S_WAIT: begin
                    if (wait_cnt_reg == 3'd0) begin
                        state_reg     <= S_IDLE;
                        hreadyout_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 3'd1;
                    end
                end
                S_ERR1: begin
                    state_reg     <= S_ERR2;
                    hreadyout_reg <= 1'b1;
                    hresp_reg     <= 1'b1;
                end
                default: begin
                    // IDLE and ERR2 both accept a new address phase.
                    if (accept && illegal) begin
                        state_reg     <= S_ERR1;
                        hreadyout_reg <= 1'b0;
                        hresp_reg     <= 1'b1;
                    end else if (legal_accept && (WAIT_STATES > 0)) begin
                        state_reg     <= S_WAIT;
                        wait_cnt_reg  <= 3'(WAIT_STATES - 1);
                        hreadyout_reg <= 1'b0;
                        hresp_reg     <= 1'b0;
                    end else begin
                        state_reg     <= S_IDLE;
                        hreadyout_reg <= 1'b1;
                        hresp_reg     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign hreadyout = hreadyout_reg;
    assign hresp     = hresp_reg;
    assign hrdata    = hrdata_reg;

endmodule

// File: tb/tb_ahb_mem_slave_p.sv
// Scoreboard bench for ahb_mem_slave_p: a zero-wait and a two-wait instance share one AHB bus.
module tb_ahb_mem_slave_p;
    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        hsel0 = 1'b0;
    logic        hsel2 = 1'b0;
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [2:0]  hburst = '0;
    logic [3:0]  hprot = 4'b0011;
    logic [1:0]  htrans = '0;
    logic [31:0] hwdata = '0;
    logic        use_ws2 = 1'b0;

    logic        hreadyout0, hresp0, hreadyout2, hresp2;
    logic [31:0] hrdata0, hrdata2;
    logic        bus_hready, act_hsel, act_resp;
    logic [31:0] act_rdata;

    assign bus_hready = use_ws2 ? hreadyout2 : hreadyout0;
    assign act_hsel   = use_ws2 ? hsel2 : hsel0;
    assign act_resp   = use_ws2 ? hresp2 : hresp0;
    assign act_rdata  = use_ws2 ? hrdata2 : hrdata0;

`ifdef AHB_MEM_SLAVE_PROT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif

    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;
    localparam logic [3:0] PRIV = 4'b0011;
    localparam logic [3:0] USER = 4'b0000;

    always #5 hclk = ~hclk;

    ahb_mem_slave_p #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans), .hready(bus_hready),
        .hwdata(hwdata), .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0)
    );

    ahb_mem_slave_p #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut2 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel2), .haddr(haddr), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hprot(hprot), .htrans(htrans), .hready(bus_hready),
        .hwdata(hwdata), .hreadyout(hreadyout2), .hresp(hresp2), .hrdata(hrdata2)
    );

    typedef struct {
        int          id;
        logic        is_read;
        logic        err;
        logic [31:0] data;
        int          waits;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one address phase; return just after the edge that accepts it, with its write data driven.
    task automatic xfer(input int id, input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [1:0] trans, input logic [3:0] prot, input logic [31:0] wdata,
                        input logic err, input logic [31:0] rdata);
        exp_t e;
        bit   done;
        e.id      = id;
        e.is_read = !wr;
        e.err     = err;
        e.data    = rdata;
        e.waits   = err ? 1 : (use_ws2 ? 2 : 0);
        sb_q.push_back(e);
        if (use_ws2) hsel2 = 1'b1;
        else         hsel0 = 1'b1;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        htrans = trans;
        hprot  = prot;
        done   = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge hclk);
            if (bus_hready) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout id=%0d: got hready=%b expected 1", id, bus_hready);
        end
        @(posedge hclk);
        #1;
        hwdata = wdata;
    endtask

    task automatic idle(input int n);
        htrans = 2'b00;
        hsel0  = 1'b0;
        hsel2  = 1'b0;
        hburst = 3'b000;
        repeat (n) begin
            @(posedge hclk);
            #1;
        end
    endtask

    // Monitor: counts wait cycles of each data phase and checks the popped expectation on completion.
    initial begin : monitor
        bit   pend;
        int   wcnt;
        exp_t e;
        pend = 1'b0;
        wcnt = 0;
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_dphase: got data phase expected none");
                        pend = 1'b0;
                    end else if (!bus_hready) begin
                        wcnt++;
                        check($sformatf("wait_resp id=%0d", sb_q[0].id), 32'(act_resp), 32'(sb_q[0].err));
                    end else begin
                        e = sb_q.pop_front();
                        check($sformatf("waits id=%0d", e.id), 32'(wcnt), 32'(e.waits));
                        check($sformatf("hresp id=%0d", e.id), 32'(act_resp), 32'(e.err));
                        if (e.is_read)
                            check($sformatf("hrdata id=%0d", e.id), act_rdata, e.data);
                        $display("txn %0d %s resp=%0d waits=%0d hrdata=%h", e.id,
                                 e.is_read ? "RD" : "WR", act_resp, wcnt, act_rdata);
                        pend = 1'b0;
                    end
                end else begin
                    check("idle_ready_resp", {30'd0, bus_hready, act_resp}, 32'd2);
                end
                if (act_hsel && bus_hready && htrans[1]) begin
                    pend = 1'b1;
                    wcnt = 0;
                end
            end
        end
    end

    initial begin
        hresetn = 1'b0;
        repeat (3) @(posedge hclk);
        #1 hresetn = 1'b1;
        @(negedge hclk);
        check("rst_hreadyout0", 32'(hreadyout0), 32'd1);
        check("rst_hresp0", 32'(hresp0), 32'd0);
        check("rst_hrdata0", hrdata0, 32'd0);
        check("rst_hreadyout2", 32'(hreadyout2), 32'd1);
        check("rst_hresp2", 32'(hresp2), 32'd0);
        check("rst_hrdata2", hrdata2, 32'd0);
        @(posedge hclk);
        #1;

        // Zero-wait instance: write then back-to-back read with forwarding.
        xfer(1,  32'h10,  1'b1, 3'd2, NS, PRIV, 32'hDEADBEEF, 1'b0, 32'h0);
        xfer(2,  32'h10,  1'b0, 3'd2, NS, PRIV, 32'h0,        1'b0, 32'hDEADBEEF);
        idle(2);
        // Byte and halfword lanes.
        xfer(3,  32'h10,  1'b1, 3'd2, NS, PRIV, 32'h11223344, 1'b0, 32'h0);
        xfer(4,  32'h13,  1'b1, 3'd0, NS, PRIV, 32'hAB000000, 1'b0, 32'h0);
        xfer(5,  32'h14,  1'b1, 3'd2, NS, PRIV, 32'h55667788, 1'b0, 32'h0);
        xfer(6,  32'h14,  1'b1, 3'd1, NS, PRIV, 32'h0000BEEF, 1'b0, 32'h0);
        xfer(7,  32'h10,  1'b0, 3'd2, NS, PRIV, 32'h0,        1'b0, 32'hAB223344);
        xfer(8,  32'h14,  1'b0, 3'd2, NS, PRIV, 32'h0,        1'b0, 32'h5566BEEF);
        idle(2);
        // Illegal accesses: out of range, unaligned, oversize; word 0 must survive.
        xfer(9,  32'h00,  1'b1, 3'd2, NS, PRIV, 32'h0BADF00D, 1'b0, 32'h0);
        xfer(10, 32'h400, 1'b1, 3'd2, NS, PRIV, 32'h12345678, 1'b1, 32'h0);
        xfer(11, 32'h01,  1'b1, 3'd1, NS, PRIV, 32'hFFFF0000, 1'b1, 32'h0);
        xfer(12, 32'h04,  1'b1, 3'd3, NS, PRIV, 32'hFFFFFFFF, 1'b1, 32'h0);
        xfer(13, 32'h00,  1'b0, 3'd2, NS, PRIV, 32'h0,        1'b0, 32'h0BADF00D);
        xfer(14, 32'h14,  1'b0, 3'd2, NS, PRIV, 32'h0,        1'b0, 32'h5566BEEF);
        xfer(15, 32'h400, 1'b0, 3'd2, NS, PRIV, 32'h0,        1'b1, 32'h5566BEEF);
        xfer(16, 32'h02,  1'b0, 3'd1, NS, PRIV, 32'h0,        1'b0, 32'h0BADF00D);
        idle(2);
        // INCR4 write, forwarded read of the last beat, INCR4 readback.
        hburst = 3'b011;
        xfer(17, 32'h40,  1'b1, 3'd2, NS, PRIV, 32'hA0000000, 1'b0, 32'h0);
        xfer(18, 32'h44,  1'b1, 3'd2, SQ, PRIV, 32'hA0000001, 1'b0, 32'h0);
        xfer(19, 32'h48,  1'b1, 3'd2, SQ, PRIV, 32'hA0000002, 1'b0, 32'h0);
        xfer(20, 32'h4C,  1'b1, 3'd2, SQ, PRIV, 32'hA0000003, 1'b0, 32'h0);
        hburst = 3'b000;
        xfer(21, 32'h4C,  1'b0, 3'd2, NS, PRIV, 32'h0,        1'b0, 32'hA0000003);
        hburst = 3'b011;
        xfer(22, 32'h40,  1'b0, 3'd2, NS, PRIV, 32'h0,        1'b0, 32'hA0000000);
        xfer(23, 32'h44,  1'b0, 3'd2, SQ, PRIV, 32'h0,        1'b0, 32'hA0000001);
        xfer(24, 32'h48,  1'b0, 3'd2, SQ, PRIV, 32'h0,        1'b0, 32'hA0000002);
        xfer(25, 32'h4C,  1'b0, 3'd2, SQ, PRIV, 32'h0,        1'b0, 32'hA0000003);
        idle(2);
        // Protection of word 200 (upper half) against user writes.
        xfer(26, 32'h320, 1'b1, 3'd2, NS, PRIV, 32'h88888888, 1'b0, 32'h0);
        xfer(27, 32'h320, 1'b1, 3'd2, NS, USER, 32'h77777777, PROT_ON, 32'h0);
        xfer(28, 32'h320, 1'b0, 3'd2, NS, USER, 32'h0, 1'b0, PROT_ON ? 32'h88888888 : 32'h77777777);
        xfer(29, 32'h14,  1'b1, 3'd2, NS, USER, 32'h99999999, 1'b0, 32'h0);
        xfer(30, 32'h14,  1'b0, 3'd2, NS, USER, 32'h0,        1'b0, 32'h99999999);
        idle(3);

        // Two-wait instance.
        use_ws2 = 1'b1;
        idle(1);
        xfer(31, 32'h20,  1'b1, 3'd2, NS, PRIV, 32'h13572468, 1'b0, 32'h0);
        xfer(32, 32'h20,  1'b0, 3'd2, NS, PRIV, 32'h0,        1'b0, 32'h13572468);
        xfer(33, 32'h21,  1'b1, 3'd0, NS, PRIV, 32'h0000CC00, 1'b0, 32'h0);
        xfer(34, 32'h400, 1'b1, 3'd2, NS, PRIV, 32'hFFFFFFFF, 1'b1, 32'h0);
        xfer(35, 32'h20,  1'b0, 3'd2, NS, PRIV, 32'h0,        1'b0, 32'h1357CC68);
        idle(6);

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge hclk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_mem_slave_p.md
Name: ahb_mem_slave_p

Overview:
- Parametrised AHB-Lite memory slave. Successor to the fixed 32x32 burst slave.
- Correct address/data phase pipelining, programmable wait states, byte-lane writes driven by hsize, and a two-cycle ERROR response for illegal accesses.
- Bursts follow the master-supplied haddr on every beat; no internal burst address generation.
- Sits behind the AHB decoder/mux, alongside the existing master and slave blocks.

Parameters:
- DATA_WIDTH, 32: bus data width; legal values 32 or 64.
- ADDR_WIDTH, 32: haddr width.
- MEM_DEPTH, 256: number of DATA_WIDTH-bit words; power of two, minimum 4.
- WAIT_STATES, 0: hreadyout-low cycles inserted per OKAY data phase; range 0..7.

Ports:
- hclk  in  1  clock
- hresetn  in  1  asynchronous active-low reset
- hsel  in  1  slave select
- haddr  in  ADDR_WIDTH  byte address
- hwrite  in  1  1 = write
- hsize  in  3  transfer size, 2^hsize bytes
- hburst  in  3  burst type; ignored except by the optional feature
- hprot  in  4  protection; used only by the optional feature
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hready  in  1  bus-level ready from the mux
- hwdata  in  DATA_WIDTH  write data
- hreadyout  out  1  slave ready
- hresp  out  1  0 = OKAY, 1 = ERROR
- hrdata  out  DATA_WIDTH  read data

Behaviour:
- Reset: one clock (hclk); asynchronous active-low reset (hresetn). On reset: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0, no data phase pending. Memory contents are not reset.
- Address phase accepted at a rising edge when hsel=1, hready=1 and htrans[1]=1. Registered per accepted phase: address, hwrite, hsize, lane mask.
- IDLE/BUSY transfers, or hsel=0, accept nothing; the next cycle shows hreadyout=1, hresp=0.
- Lanes: BYTES = DATA_WIDTH/8; word index = haddr >> log2(BYTES); byte offset = haddr mod BYTES.
- Error check at accept time; ERROR if any of:
  - word index >= MEM_DEPTH;
  - 2^hsize > BYTES;
  - haddr not aligned to 2^hsize.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: no data phase in progress, or a zero-wait data phase completing; hreadyout=1, hresp=0.
  - Legal accept with WAIT_STATES>0 -> WAIT. Counter loads WAIT_STATES-1; hreadyout=0. Counter decrements each cycle; at 0 -> IDLE (hreadyout=1 in the following cycle).
  - Illegal accept -> ERR1 (hreadyout=0, hresp=1) -> ERR2 (hreadyout=1, hresp=1) -> IDLE. A new address phase accepted during ERR2 is processed normally.
  - No address phase is accepted while hreadyout=0, because hready is then 0.
- Write: bytes selected by the lane mask are taken from hwdata in the last data-phase cycle (hreadyout=1) and committed at that edge. Unselected bytes are unchanged. Errored writes never modify memory.
- Read: hrdata is valid in the data-phase cycle where hreadyout=1 and holds until the next read completes. Unselected lanes return memory contents; full-word returns are permitted. Errored reads leave hrdata unchanged.
- Read-after-write forwarding: if a read address phase is accepted on the same edge a write to the same word commits, the written bytes are merged into hrdata. No stale data is allowed with WAIT_STATES=0.
- Back-to-back NONSEQ/SEQ at WAIT_STATES=0 sustain one transfer per cycle.
- Reset asserted mid data phase aborts the transfer. Memory is unchanged unless the commit edge already occurred.

Optional Feature:
- Macro: AHB_MEM_SLAVE_PROT_EN.
- Defined: writes with hprot[1]=0 (user access) to word index >= MEM_DEPTH/2 take the ERROR path; memory is not modified. User reads of the same region are allowed.
- Undefined: hprot is ignored entirely; no protection logic is synthesised.

Test Plan:
- WAIT_STATES=0, DATA_WIDTH=32: write NONSEQ 0x10 = 0xDEADBEEF, then read 0x10 -> hreadyout never low; hrdata=0xDEADBEEF one cycle after the read address phase.
- WAIT_STATES=2: single read of 0x20 -> hreadyout=0 for exactly 2 cycles, then 1 with valid hrdata; hresp=0 throughout.
- Byte write hsize=0 to 0x13 with hwdata=0xAB000000 over an existing word 0x11223344 -> readback 0xAB223344.
- Illegal accesses -> ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1); target word unchanged:
  - write to 0x400 with MEM_DEPTH=256;
  - hsize=1 at 0x01 (unaligned).
- INCR4 write 0x40..0x4C, immediately followed by a read of 0x4C at WAIT_STATES=0 -> forwarding returns the last written word; a subsequent INCR4 read matches all 4 words.
- With AHB_MEM_SLAVE_PROT_EN: user (hprot=0000) write to word 200 -> ERROR. Privileged (hprot=0010) write to word 200 -> OKAY. User write to word 5 -> OKAY.
